// File: rtl/spi_master_ctrl.sv
// SPI master for the slave/RAM link: serialises one 11-bit command frame per host
// handshake and, for read-data commands, clocks back an 8-bit reply on MISO.
`timescale 1ns/1ps

module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GUARD   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_MAX   = (RD_WAIT > 11) ? RD_WAIT : 11;
  localparam int unsigned BIT_W     = $clog2(BIT_MAX);
  localparam int unsigned GUARD_CYC = GUARD * CLK_DIV;
  localparam int unsigned GRD_W     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_READ,
    S_GUARD
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [GRD_W-1:0] grd_cnt;
  logic [9:0]       shreg;
  logic [6:0]       rx_sh;
  logic             is_rd;

  // bit_cnt holds the number of periods still to run after the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      grd_cnt   <= '0;
      shreg     <= '0;
      rx_sh     <= '0;
      is_rd     <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      sclk      <= 1'b0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_SHIFT;
            ss_n      <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= req_cmd[1];
            shreg     <= {req_cmd, req_data};
            is_rd     <= (req_cmd == 2'b11);
            div_cnt   <= '0;
            bit_cnt   <= BIT_W'(10);
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_SHIFT, S_WAIT, S_READ: begin
          if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // end of a bit period: falling edge, sample and advance
              sclk <= 1'b0;
              if (state == S_READ) rx_sh <= {rx_sh[5:0], miso};
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - BIT_W'(1);
                mosi    <= (state == S_SHIFT) ? shreg[9] : 1'b0;
                shreg   <= {shreg[8:0], 1'b0};
              end else begin
                mosi <= 1'b0;
                if (state == S_SHIFT && is_rd) begin
                  if (RD_WAIT == 0) begin
                    state   <= S_READ;
                    bit_cnt <= BIT_W'(7);
                  end else begin
                    state   <= S_WAIT;
                    bit_cnt <= BIT_W'(RD_WAIT - 1);
                  end
                end else if (state == S_WAIT) begin
                  state   <= S_READ;
                  bit_cnt <= BIT_W'(7);
                end else begin
                  ss_n    <= 1'b1;
                  grd_cnt <= '0;
                  if (state == S_READ) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= {rx_sh, miso};
                  end
                  if (GUARD_CYC == 0) begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                  end else begin
                    state <= S_GUARD;
                  end
                end
              end
            end
          end
        end

        S_GUARD: begin
          if (grd_cnt == GRD_W'(GUARD_CYC - 1)) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            grd_cnt <= grd_cnt + GRD_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master that drives the 4-wire link into the team's SPI slave/RAM subsystem. It accepts one command per handshake from a host-side request port, serialises the slave's frame format (command-select bit, 2-bit command, 8-bit payload), and, for read-data commands, clocks back the 8-bit reply on MISO. It presents the reply on a single-cycle response strobe. It sits between the system controller and the off-block SPI pins.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
RD_WAIT, 2, SCLK periods of turnaround (MOSI=0) between end of a read-data command and the first MISO sample.
GUARD, 2, SS_n-high half-periods (in units of CLK_DIV clk cycles) enforced between frames.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
req_valid  in  1  host request valid
req_ready  out  1  master can accept a request
req_cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
req_data  in  8  payload (address/data; don't-care bits still shifted for 11)
rsp_valid  out  1  one-cycle pulse: rsp_data valid (cmd 11 only)
rsp_data  out  8  byte read from slave; held until next rsp_valid
busy  out  1  high from accept until guard expires
sclk  out  1  SPI clock, CPOL=0
ss_n  out  1  slave select, active low
mosi  out  1  serial data to slave
miso  in  1  serial data from slave

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs registered.
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00, sclk=0, ss_n=1, mosi=0. Reset asserted mid-frame aborts immediately to these values; no rsp_valid is produced for the aborted frame.
- Accept: req_valid && req_ready at rising clk edge T. {req_cmd, req_data} is latched. req_ready=0 and busy=1 from T+1. req_ready is high only in IDLE. req_valid while not ready is ignored; it is not queued.
- Frame shift register: 11 bits, MSB first = {req_cmd[1], req_cmd[1:0], req_data[7:0]}. The first bit is the slave's write/read select.
- Bit period: sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi updates only at the start of each low half, including the cycle ss_n falls. The slave samples on the sclk rising edge.
- States:
  - IDLE: ss_n=1, sclk=0.
  - SHIFT: ss_n=0 from T+1 with mosi=bit10. Runs 11 bit periods.
  - WAIT: cmd 11 only. Runs RD_WAIT periods with mosi=0.
  - READ: cmd 11 only. Runs 8 periods with mosi=0. miso is sampled into rx shift at the last clk of each sclk-high half (just before the falling edge), MSB first.
  - GUARD: ss_n=1, sclk=0, mosi=0 for GUARD*CLK_DIV cycles, then returns to IDLE (req_ready=1, busy=0).
- SS_n low duration: cmd 00/01/10 is 22*CLK_DIV cycles. Cmd 11 is (11+RD_WAIT+8)*2*CLK_DIV cycles. SS_n always rises with sclk low, at the end of the last high half.
- Response: for cmd 11, rsp_data updates and rsp_valid pulses for 1 cycle on the same edge ss_n rises. There is no response for other commands.
- Counters:
  - Divider counter: 0..CLK_DIV-1.
  - Bit counter: counts down with no wrap. Frames never chain without passing through GUARD.
- Back-to-back: a request held valid during GUARD is accepted on the first IDLE cycle.

Test Plan:
- CLK_DIV=2, cmd 00, data 8'hA5 -> ss_n low 44 clk cycles. mosi bits on 11 rising sclk edges = 0,0,0,1,0,1,0,0,1,0,1. No rsp_valid. req_ready returns 4 cycles after ss_n rises.
- cmd 01, data 8'h3C, then cmd 10 with req_valid held high -> second frame's ss_n falls exactly GUARD*CLK_DIV+1 cycles after first ss_n rise. Second frame MOSI = 1,1,0,0,0,1,1,1,1,0,0.
- cmd 11, slave model returns 8'hC3 after RD_WAIT=2 -> ss_n low 84 cycles (CLK_DIV=2). rsp_valid single pulse coincident with ss_n rise. rsp_data=8'hC3 and held afterward.
- req_valid pulsed while busy -> ignored. req_ready stays 0. Only the original frame appears on the pins.
- rst_n asserted at bit 5 of a cmd 11 frame -> same cycle ss_n=1, sclk=0, mosi=0, req_ready=1. No rsp_valid. The next request produces a clean full frame.
- CLK_DIV=1 -> sclk toggles every clk. A cmd 00 frame has ss_n low for 22 cycles. Bit ordering is identical to the first scenario.
